// File: rtl/arm_mem_pkg.sv
// Shared types and sizes for the unified-RAM port arbiter of the multicycle ARM32 core.
package arm_mem_pkg;

  localparam int MEM_ADDR_W = 11;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

  function automatic arb_owner_t other_owner(input arb_owner_t owner);
    return (owner == OWN_IF) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEMARB_RR_EN selects round-robin on conflict; otherwise data always wins.
module mem_arb_pick
  import arm_mem_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  arb_owner_t last_owner_i,
  output arb_owner_t winner_o,
  output logic       valid_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    winner_o = OWN_IF;
    valid_o  = if_req_i | d_req_i;
`ifdef MEMARB_RR_EN
    if (if_req_i && d_req_i) begin
      winner_o = other_owner(last_owner_i);
    end else if (d_req_i) begin
      winner_o = OWN_D;
    end
`else
    if (d_req_i) begin
      winner_o = OWN_D;
    end
`endif
  end

`ifndef MEMARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = (last_owner_i == OWN_D);
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified RAM between instruction fetch and load/store.
// Optional round-robin priority with MEMARB_RR_EN; default is fixed data-over-fetch.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  arb_state_t        state_q;
  arb_owner_t        owner_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_w_en_q;
  logic              if_gnt_q;
  logic              d_gnt_q;
  logic              if_rvalid_q;
  logic              d_rvalid_q;

  arb_owner_t        last_owner;
  arb_owner_t        pick_winner;
  logic              pick_valid;
  logic [ADDR_W-1:0] win_addr_d;
  logic [DATA_W-1:0] win_wdata_d;
  logic              win_we_d;

  mem_arb_pick u_pick (
    .if_req_i     (if_req),
    .d_req_i      (d_req),
    .last_owner_i (last_owner),
    .winner_o     (pick_winner),
    .valid_o      (pick_valid)
  );

  // Fetch is read-only, so it never carries write data.
  assign win_addr_d  = (pick_winner == OWN_D) ? d_addr : if_addr;
  assign win_wdata_d = (pick_winner == OWN_D) ? d_wdata : '0;
  assign win_we_d    = (pick_winner == OWN_D) && d_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_w_en_q  <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      ram_w_en_q  <= 1'b0;
      case (state_q)
        ARB_ISSUE: begin
          // During ISSUE the write enable register holds the latched we.
          if (ram_w_en_q) begin
            state_q <= ARB_IDLE;
          end else begin
            state_q     <= ARB_RESP;
            if_rvalid_q <= (owner_q == OWN_IF);
            d_rvalid_q  <= (owner_q == OWN_D);
          end
        end
        default: begin
          if (pick_valid) begin
            state_q     <= ARB_ISSUE;
            owner_q     <= pick_winner;
            ram_addr_q  <= win_addr_d;
            ram_wdata_q <= win_wdata_d;
            ram_w_en_q  <= win_we_d;
            if_gnt_q    <= (pick_winner == OWN_IF);
            d_gnt_q     <= (pick_winner == OWN_D);
          end else begin
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

`ifdef MEMARB_RR_EN
  arb_owner_t last_owner_q;
  logic       arb_point;

  assign arb_point = (state_q == ARB_IDLE) || (state_q == ARB_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_IF;
    end else if (arb_point && pick_valid) begin
      last_owner_q <= pick_winner;
    end
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_w_en  = ram_w_en_q;
  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = ram_rdata;
  assign d_rdata   = ram_rdata;
  assign busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed timing tests plus random
// fetch/load/store traffic checked by a queue scoreboard against a memory model.
module tb_mem_port_arbiter;
  import arm_mem_pkg::*;

  localparam int AW = MEM_ADDR_W;
  localparam int DW = MEM_DATA_W;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_w_en;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] if_exp[$];
  logic [31:0] d_exp[$];
  logic [31:0] ref_mem[int];

`ifdef MEMARB_RR_EN
  localparam int PRIO_D_DROP  = 6;
  localparam int PRIO_IF_DROP = 8;
  int prio_exp [1:8] = '{2, 0, 1, 0, 2, 0, 1, 0};
`else
  localparam int PRIO_D_DROP  = 4;
  localparam int PRIO_IF_DROP = 6;
  int prio_exp [1:8] = '{2, 0, 2, 0, 1, 0, 0, 0};
`endif

  mem_port_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_w_en  (ram_w_en),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    if (a == 32'h10) return 32'hE3A00001;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Physical RAM: synchronous read, data valid the cycle after the address.
  logic [31:0] ram_mem     [0:(1<<AW)-1];
  bit          ram_written [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_w_en) begin
      ram_mem[ram_addr]     <= ram_wdata;
      ram_written[ram_addr] <= 1'b1;
    end
    ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_word(int'(ram_addr));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input bit is_d, output bit got);
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (is_d ? d_gnt : if_gnt) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard monitor: pops the expected read data whenever a valid pulse shows.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if_rvalid || d_rvalid) check("rvalid_both", 32'(if_rvalid & d_rvalid), 0);
      if (if_gnt || d_gnt)       check("gnt_both", 32'(if_gnt & d_gnt), 0);
      if (if_rvalid) begin
        check("if_rvalid_expected", 32'(if_exp.size() != 0), 1);
        if (if_exp.size() != 0) check("if_rdata", if_rdata, if_exp.pop_front());
      end
      if (d_rvalid) begin
        check("d_rvalid_expected", 32'(d_exp.size() != 0), 1);
        if (d_exp.size() != 0) check("d_rdata", d_rdata, d_exp.pop_front());
      end
    end
  end

  task automatic fetch_driver(input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      int gap;
      bit got;
      tick();
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        if_req = 1'b0;
        repeat (gap) tick();
      end
      a = $urandom_range(0, 32'h3FF);
      if_addr = AW'(a);
      if_req  = 1'b1;
      if_exp.push_back(ref_read(a));
      wait_gnt(1'b0, got);
      check("if_gnt_rand", 32'(got), 1);
    end
    tick();
    if_req = 1'b0;
  endtask

  task automatic data_driver(input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      int gap;
      bit got;
      logic we;
      logic [31:0] wd;
      tick();
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        d_req = 1'b0;
        repeat (gap) tick();
      end
      a  = $urandom_range(32'h400, 32'h40F);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      d_addr  = AW'(a);
      d_we    = we;
      d_wdata = wd;
      d_req   = 1'b1;
      if (we) ref_mem[a] = wd;
      else    d_exp.push_back(ref_read(a));
      wait_gnt(1'b1, got);
      check("d_gnt_rand", 32'(got), 1);
    end
    tick();
    d_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) sample();
    check("reset_ram_addr", 32'(ram_addr), 0);
    check("reset_ctrl", {26'd0, ram_w_en, if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 0);
    tick();
    rst_n = 1'b1;

    // Lone fetch of 0x010
    tick(); if_req = 1'b1; if_addr = 11'h010; if_exp.push_back(ref_read(32'h010));
    sample(); check("f1_c0_busy", 32'(busy), 0);
    tick(); sample();
    check("f1_c1_gnt", 32'(if_gnt), 1);
    check("f1_c1_addr", 32'(ram_addr), 32'h010);
    tick(); if_req = 1'b0; sample();
    check("f1_c2_rvalid", 32'(if_rvalid), 1);
    check("f1_c2_rdata", if_rdata, 32'hE3A00001);
    tick(); sample();
    check("f1_c3_busy", 32'(busy), 0);

    // Store 0xDEADBEEF to 0x200, then load it back
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 11'h200; d_wdata = 32'hDEADBEEF;
    ref_mem[32'h200] = 32'hDEADBEEF;
    sample();
    tick(); sample();
    check("st_c1_gnt_wen", {30'd0, d_gnt, ram_w_en}, 32'h3);
    check("st_c1_addr", 32'(ram_addr), 32'h200);
    check("st_c1_wdata", ram_wdata, 32'hDEADBEEF);
    tick(); d_req = 1'b0; d_we = 1'b0; sample();
    check("st_c2_quiet", {29'd0, d_gnt, ram_w_en, d_rvalid, busy}, 0);
    tick(); d_req = 1'b1; d_addr = 11'h200; d_exp.push_back(ref_read(32'h200));
    sample();
    tick(); sample(); check("ld_c1_gnt", 32'(d_gnt), 1);
    tick(); d_req = 1'b0; sample();
    check("ld_c2_rvalid", 32'(d_rvalid), 1);
    check("ld_c2_rdata", d_rdata, 32'hDEADBEEF);
    tick(); sample(); check("ld_c3_rvalid_low", 32'(d_rvalid), 0);

    // Reset asserted during the ISSUE cycle of a store
    tick(); d_req = 1'b1; d_we = 1'b1; d_addr = 11'h250; d_wdata = 32'h12345678;
    sample();
    tick(); sample(); check("rst_c1_wen", 32'(ram_w_en), 1);
    #1; rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    #1; check("rst_async_wen", {30'd0, ram_w_en, busy}, 0);
    tick(); tick(); rst_n = 1'b1;
    sample();
    check("post_rst_addr", 32'(ram_addr), 0);
    check("post_rst_wdata", ram_wdata, 0);
    check("post_rst_ctrl", {26'd0, ram_w_en, if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 0);
    tick(); sample();
    check("post_rst_ctrl2", {26'd0, ram_w_en, if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 0);

    // Simultaneous fetch and load: data wins the first conflict in either mode
    tick(); if_req = 1'b1; if_addr = 11'h011; d_req = 1'b1; d_we = 1'b0; d_addr = 11'h300;
    if_exp.push_back(ref_read(32'h011)); d_exp.push_back(ref_read(32'h300));
    sample();
    tick(); sample();
    check("sim_c1_gnts", {30'd0, d_gnt, if_gnt}, 32'h2);
    check("sim_c1_addr", 32'(ram_addr), 32'h300);
    tick(); d_req = 1'b0; sample();
    check("sim_c2_rvalids", {30'd0, d_rvalid, if_rvalid}, 32'h2);
    tick(); sample();
    check("sim_c3_gnts", {30'd0, d_gnt, if_gnt}, 32'h1);
    check("sim_c3_addr", 32'(ram_addr), 32'h011);
    tick(); if_req = 1'b0; sample();
    check("sim_c4_rvalids", {30'd0, d_rvalid, if_rvalid}, 32'h1);
    tick(); sample(); check("sim_c5_busy", 32'(busy), 0);

    // Back-to-back fetches 0x000, 0x001
    tick(); if_req = 1'b1; if_addr = 11'h000; if_exp.push_back(ref_read(0));
    sample();
    tick(); sample();
    check("b2b_c1_gnt", 32'(if_gnt), 1);
    check("b2b_c1_addr", 32'(ram_addr), 0);
    tick(); if_addr = 11'h001; if_exp.push_back(ref_read(1)); sample();
    check("b2b_c2_rvalid", {30'd0, if_rvalid, if_gnt}, 32'h2);
    tick(); sample();
    check("b2b_c3_gnt", 32'(if_gnt), 1);
    check("b2b_c3_addr", 32'(ram_addr), 1);
    tick(); if_req = 1'b0; sample();
    check("b2b_c4_rvalid", 32'(if_rvalid), 1);
    tick(); sample(); check("b2b_c5_busy", 32'(busy), 0);

    // Both requesters held: grant sequence follows the priority policy
    for (int c = 1; c <= 8; c++) begin
      if (prio_exp[c] == 2) d_exp.push_back(ref_read(32'h400));
      if (prio_exp[c] == 1) if_exp.push_back(ref_read(32'h020));
    end
    tick(); if_req = 1'b1; if_addr = 11'h020; d_req = 1'b1; d_we = 1'b0; d_addr = 11'h400;
    sample();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == PRIO_D_DROP)  d_req  = 1'b0;
      if (c == PRIO_IF_DROP) if_req = 1'b0;
      sample();
      check($sformatf("prio_c%0d", c), {30'd0, d_gnt, if_gnt}, 32'(prio_exp[c]));
    end
    repeat (3) begin tick(); sample(); end

    // Random concurrent traffic
    fork
      fetch_driver(60);
      data_driver(60);
    join

    for (int c = 0; c < 50 && (if_exp.size() != 0 || d_exp.size() != 0); c++) sample();
    check("if_exp_drained", 32'(if_exp.size()), 0);
    check("d_exp_drained", 32'(d_exp.size()), 0);
    repeat (3) sample();
    check("final_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
